// File: rtl/avalon_wait_ram_if.sv
// Avalon-MM bus bundle between the CPU bus controller (master) and the wait-state RAM (slave).
interface avalon_wait_ram_if;
  logic [31:0] av_address;
  logic        av_read;
  logic        av_write;
  logic [31:0] av_writedata;
  logic [3:0]  av_byteenable;
  logic        av_waitrequest;
  logic [31:0] av_readdata;

  modport master (
    output av_address, av_read, av_write, av_writedata, av_byteenable,
    input  av_waitrequest, av_readdata
  );

  modport slave (
    input  av_address, av_read, av_write, av_writedata, av_byteenable,
    output av_waitrequest, av_readdata
  );
endinterface

// File: rtl/avalon_wait_ram.sv
// Avalon-MM word RAM with programmable wait states, byte-lane writes and sticky error flags.
// Define AVALON_RAM_RANDOM_WAIT_EN to draw each transfer's wait count from a 16-bit LFSR.
module avalon_wait_ram #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2
`ifdef AVALON_RAM_RANDOM_WAIT_EN
  ,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
`endif
) (
  input  logic             clk,
  input  logic             reset,
  avalon_wait_ram_if.slave bus,
  output logic [1:0]       err,
  output logic [31:0]      access_count
);

  localparam int unsigned Words    = 2 ** DEPTH_LOG2;
  localparam logic [32:0] MemBytes = 33'(Words) << 2;

  typedef enum logic [1:0] {StIdle, StWait, StErr} state_e;

  state_e                  state_q;
  logic [3:0]              wcnt_q;
  logic [3:0]              target_q;
  logic [3:0]              target_now;
  logic [29:0]             addr_q;
  logic                    rd_q;
  logic                    wr_q;
  logic [31:0]             mem [Words];

  logic                    req;
  logic                    illegal;
  logic                    changed;
  logic                    complete;
  logic                    wait_out;
  logic                    in_range;
  logic [31:0]             offset;
  logic [DEPTH_LOG2-1:0]   index;

  assign req      = bus.av_read | bus.av_write;
  assign illegal  = bus.av_read & bus.av_write;
  assign offset   = bus.av_address - BASE_ADDR;
  assign in_range = {1'b0, offset} < MemBytes;
  assign index    = offset[DEPTH_LOG2+1:2];
  assign changed  = (bus.av_address[31:2] != addr_q) | (bus.av_read != rd_q) |
                    (bus.av_write != wr_q);

`ifdef AVALON_RAM_RANDOM_WAIT_EN
  logic [15:0] lfsr_q;
  assign target_now = 4'(32'(lfsr_q[3:0]) % (WAIT_CYCLES + 1));
`else
  assign target_now = 4'(WAIT_CYCLES);
`endif

  always_comb begin
    wait_out = 1'b1;
    complete = 1'b0;
    if (reset) begin
      case (state_q)
        StIdle: begin
          if (!req || illegal) begin
            wait_out = 1'b0;
          end else if (target_now == 4'd0) begin
            wait_out = 1'b0;
            complete = 1'b1;
          end
        end
        StWait: begin
          if (!req) begin
            wait_out = 1'b0;
          end else if (!changed && wcnt_q == target_q) begin
            wait_out = 1'b0;
            complete = 1'b1;
          end
        end
        StErr:   wait_out = 1'b0;
        default: wait_out = 1'b1;
      endcase
    end
  end

  assign bus.av_waitrequest = wait_out;
  // Out-of-range and illegal transfers both return zero.
  assign bus.av_readdata    = (complete && bus.av_read && in_range) ? mem[index] : '0;

  always_ff @(posedge clk) begin
    if (complete && bus.av_write && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.av_byteenable[i]) mem[index][8*i +: 8] <= bus.av_writedata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      wcnt_q       <= '0;
      target_q     <= '0;
      addr_q       <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      err          <= '0;
      access_count <= '0;
`ifdef AVALON_RAM_RANDOM_WAIT_EN
      lfsr_q       <= LFSR_SEED;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (req) begin
            if (illegal) begin
              state_q <= StErr;
              err[1]  <= 1'b1;
            end else if (target_now != 4'd0) begin
              state_q  <= StWait;
              wcnt_q   <= 4'd1;
              target_q <= target_now;
              addr_q   <= bus.av_address[31:2];
              rd_q     <= bus.av_read;
              wr_q     <= bus.av_write;
            end
          end
        end
        StWait: begin
          // Drop, mid-transfer change and completion all return to IDLE.
          if (!req || changed || wcnt_q == target_q) begin
            state_q <= StIdle;
            wcnt_q  <= '0;
          end else begin
            wcnt_q <= wcnt_q + 4'd1;
          end
          if (req && changed) err[1] <= 1'b1;
        end
        StErr: begin
          err[1]  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (complete) begin
        access_count <= access_count + 32'd1;
        if (!in_range) err[0] <= 1'b1;
`ifdef AVALON_RAM_RANDOM_WAIT_EN
        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`endif
      end
    end
  end

endmodule

// File: tb/tb_avalon_wait_ram.sv
// Bench for avalon_wait_ram: transaction-level model plus per-cycle output compare.
module tb_avalon_wait_ram;
`ifdef AVALON_RAM_RANDOM_WAIT_EN
  localparam int unsigned W = 3;
`else
  localparam int unsigned W = 2;
`endif
  localparam logic [31:0] BASE = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  err;
  logic [31:0] access_count;

  avalon_wait_ram_if bus ();

  avalon_wait_ram #(
    .BASE_ADDR  (BASE),
    .DEPTH_LOG2 (10),
    .WAIT_CYCLES(W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .err         (err),
    .access_count(access_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Expected outputs for the current cycle, and the transaction-level model.
  bit          chk_en = 1'b0;
  logic        exp_wait;
  logic [31:0] exp_rdata;
  logic [1:0]  exp_err;
  logic [31:0] exp_count;
  logic [31:0] mmem [int];
  logic [31:0] m_count;
  logic [1:0]  m_err;
`ifdef AVALON_RAM_RANDOM_WAIT_EN
  logic [15:0] m_lfsr;
`endif

  logic        s_wait;
  logic [31:0] s_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("waitrequest", 32'(bus.av_waitrequest), 32'(exp_wait));
      chk("readdata", bus.av_readdata, exp_rdata);
      chk("err", 32'(err), 32'(exp_err));
      chk("access_count", access_count, exp_count);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic bit m_in_range(input logic [31:0] a);
    return (a - BASE) < 32'(4 * 1024);
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    int idx;
    idx = int'((a - BASE) >> 2);
    return mmem.exists(idx) ? mmem[idx] : 32'h0;
  endfunction

  function automatic int m_target();
`ifdef AVALON_RAM_RANDOM_WAIT_EN
    return int'(m_lfsr[3:0]) % (W + 1);
`else
    return W;
`endif
  endfunction

  task automatic m_complete(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be);
    logic [31:0] v;
    if (wr && m_in_range(a)) begin
      v = m_rd(a);
      for (int i = 0; i < 4; i++) if (be[i]) v[8*i +: 8] = d[8*i +: 8];
      mmem[int'((a - BASE) >> 2)] = v;
    end
    m_count = m_count + 32'd1;
    if (!m_in_range(a)) m_err[0] = 1'b1;
`ifdef AVALON_RAM_RANDOM_WAIT_EN
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
  endtask

  task automatic sync_exp();
    exp_count = m_count;
    exp_err   = m_err;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    bus.av_read       = rd;
    bus.av_write      = wr;
    bus.av_address    = a;
    bus.av_writedata  = d;
    bus.av_byteenable = be;
  endtask

  task automatic tick();
    @(negedge clk);
    s_wait  = bus.av_waitrequest;
    s_rdata = bus.av_readdata;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle_idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    exp_wait  = 1'b0;
    exp_rdata = '0;
    tick();
    sync_exp();
  endtask

  task automatic xfer(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      output int lat, output logic [31:0] rdata, output logic [15:0] wseq);
    int t;
    t     = m_target();
    wseq  = '0;
    rdata = '0;
    drive(rd, wr, a, d, be);
    for (int c = 0; c <= t; c++) begin
      exp_wait  = (c < t);
      exp_rdata = (c == t && rd && m_in_range(a)) ? m_rd(a) : 32'h0;
      tick();
      wseq = {wseq[14:0], s_wait};
      if (c == t) begin
        rdata = s_rdata;
        m_complete(wr, a, d, be);
      end
      sync_exp();
    end
    lat = t + 1;
  endtask

  int          lat;
  logic [31:0] rd;
  logic [15:0] ws;

  initial begin
    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    m_count = '0;
    m_err   = '0;
`ifdef AVALON_RAM_RANDOM_WAIT_EN
    m_lfsr  = 16'hACE1;
`endif
    #1 reset = 1'b0;
    exp_wait  = 1'b1;
    exp_rdata = '0;
    sync_exp();
    chk_en = 1'b1;
    tick();
    chk("reset_wait", 32'(s_wait), 32'd1);
    reset = 1'b1;
    cycle_idle();

`ifndef AVALON_RAM_RANDOM_WAIT_EN
    // Byte-lane writes and read-back.
    xfer(1'b0, 1'b1, BASE, 32'hDEADBEEF, 4'b1111, lat, rd, ws);
    chk("wr_full_wait_seq", 32'(ws), 32'b110);
    xfer(1'b0, 1'b1, BASE, 32'h11223344, 4'b1100, lat, rd, ws);
    xfer(1'b1, 1'b0, BASE, 32'h0, 4'b0000, lat, rd, ws);
    chk("rd_merged", rd, 32'h1122BEEF);
    chk("rd_merged_wait_seq", 32'(ws), 32'b110);
    chk("count_3", access_count, 32'd3);
    xfer(1'b0, 1'b1, BASE + 32'd4, 32'hAABBCCDD, 4'b1111, lat, rd, ws);
    xfer(1'b0, 1'b1, BASE + 32'd4, 32'h00112233, 4'b0101, lat, rd, ws);
    xfer(1'b1, 1'b0, BASE + 32'd4, 32'h0, 4'b1111, lat, rd, ws);
    chk("rd_lanes_0101", rd, 32'hAA11CC33);
    cycle_idle();

    // Out-of-range read.
    xfer(1'b1, 1'b0, 32'h0, 32'h0, 4'b1111, lat, rd, ws);
    chk("oor_rdata", rd, 32'h0);
    chk("oor_wait_seq", 32'(ws), 32'b110);
    chk("oor_err", 32'(err), 32'b01);
    chk("oor_count", access_count, 32'd7);

    // Abort after one wait cycle, then a full fresh transfer.
    drive(1'b1, 1'b0, BASE, 32'h0, 4'b1111);
    exp_wait  = 1'b1;
    exp_rdata = '0;
    tick();
    sync_exp();
    tick();
    sync_exp();
    cycle_idle();
    chk("abort_no_count", access_count, 32'd7);
    xfer(1'b1, 1'b0, BASE, 32'h0, 4'b1111, lat, rd, ws);
    chk("abort_retry_seq", 32'(ws), 32'b110);
    chk("abort_retry_data", rd, 32'h1122BEEF);
    chk("abort_retry_count", access_count, 32'd8);

    // Address change mid-wait: protocol error, restart from IDLE.
    drive(1'b1, 1'b0, BASE, 32'h0, 4'b1111);
    exp_wait  = 1'b1;
    exp_rdata = '0;
    tick();
    sync_exp();
    drive(1'b1, 1'b0, BASE + 32'd4, 32'h0, 4'b1111);
    tick();
    m_err[1] = 1'b1;
    sync_exp();
    chk("change_err", 32'(err), 32'b11);
    xfer(1'b1, 1'b0, BASE + 32'd4, 32'h0, 4'b1111, lat, rd, ws);
    chk("change_restart_seq", 32'(ws), 32'b110);
    chk("change_restart_data", rd, 32'hAA11CC33);
    chk("change_count", access_count, 32'd9);

    // Reset during the wait of a write: write dropped, memory kept.
    drive(1'b0, 1'b1, BASE + 32'd4, 32'h0, 4'b1111);
    exp_wait  = 1'b1;
    exp_rdata = '0;
    tick();
    sync_exp();
    reset   = 1'b0;
    m_count = '0;
    m_err   = '0;
    sync_exp();
    tick();
    chk("reset_mid_wait", 32'(s_wait), 32'd1);
    chk("reset_mid_count", access_count, 32'd0);
    reset = 1'b1;
    cycle_idle();
    xfer(1'b1, 1'b0, BASE + 32'd4, 32'h0, 4'b1111, lat, rd, ws);
    chk("reset_mem_kept", rd, 32'hAA11CC33);

    // Illegal read+write: immediate zero-wait, no write, err[1].
    drive(1'b1, 1'b1, BASE, 32'hFFFFFFFF, 4'b1111);
    exp_wait  = 1'b0;
    exp_rdata = '0;
    tick();
    chk("illegal_wait_now", 32'(s_wait), 32'd0);
    m_err[1] = 1'b1;
    sync_exp();
    cycle_idle();
    chk("illegal_err", 32'(err), 32'b10);
    chk("illegal_count", access_count, 32'd1);
    xfer(1'b1, 1'b0, BASE, 32'h0, 4'b1111, lat, rd, ws);
    chk("illegal_mem_kept", rd, 32'h1122BEEF);
    chk("final_count", access_count, 32'd2);
`else
    // Random waits: first target from seed 16'hACE1 is 1 % 4 = 1.
    xfer(1'b0, 1'b1, BASE, 32'hCAFEF00D, 4'b1111, lat, rd, ws);
    chk("rand_first_lat", 32'(lat), 32'd2);
    chk("rand_first_seq", 32'(ws), 32'b10);
    for (int n = 0; n < 100; n++) begin
      xfer(1'b1, 1'b0, BASE, 32'h0, 4'b1111, lat, rd, ws);
      chk("rand_lat_range", 32'(lat >= 1 && lat <= 4), 32'd1);
      chk("rand_rdata", rd, 32'hCAFEF00D);
    end
    chk("rand_count", access_count, 32'd101);
`endif

    cycle_idle();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
